alu_seq: RTL and testbench

Parametrised WIDTH-bit ALU with registered outputs, valid/ready handshakes on input and output, full flag set, and a multi-cycle shift-add multiplier. It is the next generation of the team's ripple-carry ALU and fixes its SLT behaviour: less-than is a proper signed compare, not carry-out. It sits between the register-read stage and the writeback stage of the lab datapath. The output register provides pipeline decoupling in that position.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_seq_if.sv | 33 +++
 rtl/alu_comb.sv | 52 +++++
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_seq shared types: opcode enum and width.
// Imported by the interface, datapath and top.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SLT = 3'b100,
    OP_NOR = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master drives operands and out_ready; slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result,
    input  carry_out, overflow, zero, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result,
    output carry_out, overflow, zero, busy
  );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: logic, add/sub, signed SLT.
// MUL yields zero here; the sequencer owns the multiplier.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cf_o,
  output logic             ovf_o
);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             ovf_add;

  always_comb begin
    sub = (op_i == OP_SUB) || (op_i == OP_SLT);
    bx  = sub ? ~b_i : b_i;
    sum = {1'b0, a_i} + {1'b0, bx}
        + {{WIDTH{1'b0}}, sub};
    ovf_add = (a_i[WIDTH-1] == bx[WIDTH-1])
           && (sum[WIDTH-1] != a_i[WIDTH-1]);
    y_o   = '0;
    cf_o  = 1'b0;
    ovf_o = 1'b0;
    unique case (op_i)
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_NOR: y_o = ~(a_i | b_i);
      OP_XOR: y_o = a_i ^ b_i;
      OP_ADD, OP_SUB: begin
        y_o   = sum[WIDTH-1:0];
        cf_o  = sum[WIDTH];
        ovf_o = ovf_add;
      end
      // true signed less-than: sign of a-b corrected by overflow
      OP_SLT: begin
        y_o  = {{(WIDTH-1){1'b0}},
                sum[WIDTH-1] ^ ovf_add};
        cf_o = sum[WIDTH];
      end
      OP_MUL: y_o = '0;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a
// fixed-latency shift-add multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cf_q, cf_d;
  logic               ovf_q, ovf_d;
  logic               zf_q, zf_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   comb_y;
  logic               comb_cf;
  logic               comb_ovf;
  logic               accept;
  logic               is_mul;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i   (bus.a),
    .b_i   (bus.b),
    .op_i  (bus.op),
    .y_o   (comb_y),
    .cf_o  (comb_cf),
    .ovf_o (comb_ovf)
  );

  assign bus.in_ready  = (state_q == S_IDLE)
                      || ((state_q == S_DONE)
                          && bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_MUL);
  assign bus.result    = res_q;
  assign bus.carry_out = cf_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zf_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign is_mul   = MUL_EN && (bus.op == OP_MUL);
  assign acc_step = acc_q
                  + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    cf_d     = cf_q;
    ovf_d    = ovf_q;
    zf_d     = zf_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && bus.out_ready)
          state_d = S_IDLE;
        if (accept) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            res_d   = comb_y;
            cf_d    = comb_cf;
            ovf_d   = comb_ovf;
            zf_d    = (comb_y == '0);
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // last step folds straight into the output regs
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = acc_step[WIDTH-1:0];
          cf_d    = 1'b0;
          ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
          zf_d    = (acc_step[WIDTH-1:0] == '0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      cf_q     <= 1'b0;
      ovf_q    <= 1'b0;
      zf_q     <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      cf_q     <= cf_d;
      ovf_q    <= ovf_d;
      zf_q     <= zf_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: flags, handshakes,
// multiplier latency, backpressure and reset.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq_if #(.WIDTH(W)) bus0 ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  task automatic present(input logic v, input op_t o,
                         input logic [W-1:0] x,
                         input logic [W-1:0] y);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy,
         bus.result, bus.carry_out, bus.overflow,
         bus.zero} !== {3'b100, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_init: rdy=%b v=%b busy=%b r=%h c=%b o=%b z=%b want rdy=1 rest 0",
               bus.in_ready, bus.out_valid, bus.busy,
               bus.result, bus.carry_out, bus.overflow,
               bus.zero);
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    present(1'b1, OP_ADD, 8'h7F, 8'h01);
    @(negedge clk);
    present(1'b0, OP_ADD, 8'h00, 8'h00);
    checks++;
    if ({bus.out_valid, bus.result} !== {1'b1, 8'h80}) begin
      errors++;
      $display("FAIL reset_pre: v=%b r=%h want v=1 r=80",
               bus.out_valid, bus.result);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy,
         bus.result, bus.carry_out, bus.overflow,
         bus.zero} !== {3'b100, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_async: rdy=%b v=%b r=%h o=%b want rdy=1 v=0 r=00 o=0",
               bus.in_ready, bus.out_valid, bus.result,
               bus.overflow);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.result}
        !== {2'b10, 8'h00}) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b v=%b r=%h want rdy=1 v=0 r=00",
               bus.in_ready, bus.out_valid, bus.result);
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    present(1'b1, OP_ADD, 8'hFF, 8'h01);
    @(negedge clk);
    present(1'b0, OP_ADD, 8'h00, 8'h00);
    checks++;
    if ({bus.out_valid, bus.result, bus.carry_out,
         bus.overflow, bus.zero}
        !== {1'b1, 8'h00, 3'b101}) begin
      errors++;
      $display("FAIL add_ff_01: v=%b r=%h c=%b o=%b z=%b want v=1 r=00 c=1 o=0 z=1",
               bus.out_valid, bus.result, bus.carry_out,
               bus.overflow, bus.zero);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_consumed: v=%b want 0",
               bus.out_valid);
    end
  endtask

  task automatic test_ops();
    op_t        ops [9] = '{OP_SUB, OP_SLT, OP_SLT,
                            OP_AND, OP_OR, OP_NOR,
                            OP_XOR, OP_ADD, OP_SUB};
    logic [7:0] va  [9] = '{8'h80, 8'h80, 8'h01,
                            8'hF0, 8'h00, 8'hF0,
                            8'hAA, 8'h7F, 8'h05};
    logic [7:0] vb  [9] = '{8'h01, 8'h01, 8'h80,
                            8'h3C, 8'h00, 8'h0F,
                            8'h55, 8'h01, 8'h05};
    logic [7:0] er  [9] = '{8'h7F, 8'h01, 8'h00,
                            8'h30, 8'h00, 8'h00,
                            8'hFF, 8'h80, 8'h00};
    logic [2:0] ef  [9] = '{3'b110, 3'b100, 3'b001,
                            3'b000, 3'b001, 3'b001,
                            3'b000, 3'b010, 3'b101};
    for (int i = 0; i < 9; i++) begin
      present(1'b1, ops[i], va[i], vb[i]);
      @(negedge clk);
      present(1'b0, OP_AND, 8'h00, 8'h00);
      checks++;
      if ({bus.out_valid, bus.result, bus.carry_out,
           bus.overflow, bus.zero}
          !== {1'b1, er[i], ef[i]}) begin
        errors++;
        $display("FAIL op%0d_%s: v=%b r=%h cov z=%b%b%b want r=%h cov z=%b",
                 i, ops[i].name(), bus.out_valid,
                 bus.result, bus.carry_out, bus.overflow,
                 bus.zero, er[i], ef[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    logic [7:0] va [3] = '{8'h0F, 8'h10, 8'h25};
    logic [7:0] vb [3] = '{8'h11, 8'h10, 8'h00};
    logic [7:0] er [3] = '{8'hFF, 8'h00, 8'h00};
    logic [2:0] ef [3] = '{3'b000, 3'b011, 3'b001};
    for (int k = 0; k < 3; k++) begin
      int lat   = 0;
      int bcnt  = 0;
      bit rdy_e = 1'b0;
      present(1'b1, OP_MUL, va[k], vb[k]);
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (i == 1) present(1'b0, OP_AND, 8'h00, 8'h00);
        if (bus.busy) begin
          bcnt++;
          if (bus.in_ready) rdy_e = 1'b1;
        end
        if (bus.out_valid) begin
          lat = i;
          break;
        end
      end
      checks++;
      if (lat != 9 || bcnt != 8 || rdy_e) begin
        errors++;
        $display("FAIL mul%0d_timing: lat=%0d busy=%0d rdy_in_mul=%b want lat=9 busy=8 rdy=0",
                 k, lat, bcnt, rdy_e);
      end
      checks++;
      if ({bus.result, bus.carry_out, bus.overflow,
           bus.zero} !== {er[k], ef[k]}) begin
        errors++;
        $display("FAIL mul%0d_value: r=%h cov z=%b%b%b want r=%h cov z=%b",
                 k, bus.result, bus.carry_out,
                 bus.overflow, bus.zero, er[k], ef[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    present(1'b1, OP_ADD, 8'h12, 8'h34);
    @(negedge clk);
    present(1'b1, OP_ADD, 8'h01, 8'h02);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result,
           bus.carry_out, bus.overflow, bus.zero}
          !== {2'b10, 8'h46, 3'b000}) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b rdy=%b r=%h want v=1 rdy=0 r=46",
                 i, bus.out_valid, bus.in_ready,
                 bus.result);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy: rdy=%b want 1",
               bus.in_ready);
    end
    @(negedge clk);
    present(1'b0, OP_AND, 8'h00, 8'h00);
    checks++;
    if ({bus.out_valid, bus.result} !== {1'b1, 8'h03}) begin
      errors++;
      $display("FAIL bp_next: v=%b r=%h want v=1 r=03",
               bus.out_valid, bus.result);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    op_t        ops [4] = '{OP_ADD, OP_SUB,
                            OP_XOR, OP_ADD};
    logic [7:0] va  [4] = '{8'h01, 8'h00, 8'hFF, 8'h80};
    logic [7:0] vb  [4] = '{8'h01, 8'h01, 8'hFF, 8'h80};
    logic [7:0] er  [4] = '{8'h02, 8'hFF, 8'h00, 8'h00};
    logic [2:0] ef  [4] = '{3'b000, 3'b000,
                            3'b001, 3'b111};
    present(1'b1, ops[0], va[0], vb[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) present(1'b1, ops[i+1], va[i+1], vb[i+1]);
      else       present(1'b0, OP_AND, 8'h00, 8'h00);
      checks++;
      if ({bus.out_valid, bus.result, bus.carry_out,
           bus.overflow, bus.zero}
          !== {1'b1, er[i], ef[i]}) begin
        errors++;
        $display("FAIL b2b%0d: v=%b r=%h cov z=%b%b%b want r=%h cov z=%b",
                 i, bus.out_valid, bus.result,
                 bus.carry_out, bus.overflow, bus.zero,
                 er[i], ef[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mul_en0();
    bus0.in_valid = 1'b1;
    bus0.op       = OP_MUL;
    bus0.a        = 8'h03;
    bus0.b        = 8'h05;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.busy, bus0.result,
         bus0.carry_out, bus0.overflow, bus0.zero}
        !== {2'b10, 8'h00, 3'b001}) begin
      errors++;
      $display("FAIL mul_en0: v=%b busy=%b r=%h z=%b want v=1 busy=0 r=00 z=1",
               bus0.out_valid, bus0.busy, bus0.result,
               bus0.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    present(1'b1, OP_MUL, 8'h0F, 8'h11);
    @(negedge clk);
    present(1'b0, OP_AND, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.in_ready, bus.out_valid}
        !== 3'b010) begin
      errors++;
      $display("FAIL rst_mid_mul: busy=%b rdy=%b v=%b want busy=0 rdy=1 v=0",
               bus.busy, bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    present(1'b1, OP_ADD, 8'h02, 8'h03);
    @(negedge clk);
    present(1'b0, OP_AND, 8'h00, 8'h00);
    checks++;
    if ({bus.out_valid, bus.result, bus.zero}
        !== {1'b1, 8'h05, 1'b0}) begin
      errors++;
      $display("FAIL rst_then_add: v=%b r=%h want v=1 r=05",
               bus.out_valid, bus.result);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.out_ready  = 1'b1;
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.op        = OP_AND;
    bus0.a         = '0;
    bus0.b         = '0;
    present(1'b0, OP_AND, 8'h00, 8'h00);
    test_reset();
    test_add();
    test_ops();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_mul_en0();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
